// File: rtl/nn_io_pkg.sv
// Shared sizing constants and FSM encoding for the frame loader / inference engine link.
package nn_io_pkg;

    localparam int N_PIX  = 784;
    localparam int BYTE_W = 8;
    localparam int PIX_W  = 2 * BYTE_W;
    localparam int ADDR_W = 10;
    localparam int CLS_W  = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;
    localparam logic [1:0] ST_BUSY  = 2'd3;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [PIX_W-1:0]  data;
    } buf_wr_t;

    function automatic logic is_last_pix(input logic [ADDR_W-1:0] cnt);
        return cnt == ADDR_W'(N_PIX - 1);
    endfunction

endpackage

// File: rtl/rx_strobe_sync.sv
// Brings the UART completion strobe into clk and emits a one-cycle pulse per rising edge.
module rx_strobe_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic byte_stb
);

    logic sync1_q, sync2_q, prev_q;
    logic sync1_d, sync2_d, prev_d;

    always_comb begin
        sync1_d = async_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign byte_stb = sync2_q & ~prev_q;

endmodule

// File: rtl/pixel_frame_loader.sv
// Assembles UART byte pairs into a 784-pixel frame buffer, kicks the engine and latches its class.
module pixel_frame_loader
    import nn_io_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [BYTE_W-1:0] rx_byte,
    input  logic              rx_complete_async,
    input  logic [ADDR_W-1:0] pix_addr,
    output logic [PIX_W-1:0]  pix_data,
    output logic              nn_start,
    input  logic              nn_done,
    input  logic [CLS_W-1:0]  nn_class,
    output logic [CLS_W-1:0]  class_out,
    output logic              class_valid,
    output logic              frame_busy,
    output logic              overrun
);

    logic byte_stb;

    rx_strobe_sync u_rx_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (rx_complete_async),
        .byte_stb (byte_stb)
    );

    logic [1:0]        state_q, state_d;
    logic              phase_q, phase_d;
    logic [BYTE_W-1:0] low_q, low_d;
    logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
    logic              overrun_q, overrun_d;
    logic [CLS_W-1:0]  class_q, class_d;
    logic              class_valid_q, class_valid_d;
    logic              nn_start_q, nn_start_d;
    logic              frame_busy_q, frame_busy_d;
    logic [PIX_W-1:0]  pix_data_q, pix_data_d;
    buf_wr_t           wr;

    logic [PIX_W-1:0] buf_mem [0:N_PIX-1];

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        low_d         = low_q;
        pix_cnt_d     = pix_cnt_q;
        overrun_d     = overrun_q;
        class_d       = class_q;
        class_valid_d = class_valid_q;
        nn_start_d    = 1'b0;
        wr.en         = 1'b0;
        wr.addr       = pix_cnt_q;
        wr.data       = {rx_byte, low_q};

        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d       = ST_LOAD;
                    phase_d       = 1'b0;
                    pix_cnt_d     = '0;
                    class_valid_d = 1'b0;
                    // A byte landing with the request is still dropped, flagged after the clear.
                    overrun_d     = byte_stb;
                end else if (byte_stb) begin
                    overrun_d = 1'b1;
                end
            end
            ST_LOAD: begin
                if (load_start) begin
                    phase_d   = 1'b0;
                    pix_cnt_d = '0;
                    overrun_d = 1'b0;
                end else if (byte_stb) begin
                    if (!phase_q) begin
                        low_d   = rx_byte;
                        phase_d = 1'b1;
                    end else begin
                        wr.en     = 1'b1;
                        phase_d   = 1'b0;
                        pix_cnt_d = pix_cnt_q + 1'b1;
                        if (is_last_pix(pix_cnt_q)) begin
                            state_d    = ST_READY;
                            nn_start_d = 1'b1;
                        end
                    end
                end
            end
            ST_READY: begin
                state_d = ST_BUSY;
                if (byte_stb) overrun_d = 1'b1;
            end
            default: begin
                if (byte_stb) overrun_d = 1'b1;
                if (nn_done) begin
                    class_d       = nn_class;
                    class_valid_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
        endcase

        frame_busy_d = (state_d != ST_IDLE);
    end

    // Out-of-range addresses read as zero rather than aliasing into the frame.
    always_comb begin
        pix_data_d = '0;
        if (pix_addr < ADDR_W'(N_PIX)) pix_data_d = buf_mem[pix_addr];
    end

    always_ff @(posedge clk) begin
        if (wr.en) buf_mem[wr.addr] <= wr.data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            phase_q       <= 1'b0;
            low_q         <= '0;
            pix_cnt_q     <= '0;
            overrun_q     <= 1'b0;
            class_q       <= '0;
            class_valid_q <= 1'b0;
            nn_start_q    <= 1'b0;
            frame_busy_q  <= 1'b0;
            pix_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            low_q         <= low_d;
            pix_cnt_q     <= pix_cnt_d;
            overrun_q     <= overrun_d;
            class_q       <= class_d;
            class_valid_q <= class_valid_d;
            nn_start_q    <= nn_start_d;
            frame_busy_q  <= frame_busy_d;
            pix_data_q    <= pix_data_d;
        end
    end

    assign pix_data    = pix_data_q;
    assign nn_start    = nn_start_q;
    assign class_out   = class_q;
    assign class_valid = class_valid_q;
    assign frame_busy  = frame_busy_q;
    assign overrun     = overrun_q;

endmodule

// File: doc/pixel_frame_loader.md
Name: pixel_frame_loader

Overview:
- Sits between the UART byte receiver and the final_destination inference engine.
- Brings the receiver's completion strobe into the system clock domain and assembles byte pairs into 16-bit pixels.
- Buffers one full 784-pixel frame, then issues a one-cycle start to the engine and serves pixels by address while the engine runs.
- Latches the engine's class result on done and returns to idle for the next frame.

Parameters:
- N_PIX, 784, pixels per frame.
- PIX_W, 16, stored pixel width; equals 2*BYTE_W.
- BYTE_W, 8, UART payload width.
- ADDR_W, 10, pixel address width; must satisfy 2^ADDR_W >= N_PIX.
- CLS_W, 4, class-result width.

Ports:
- clk, input, 1, system clock (master_clk at top level).
- rst_n, input, 1, asynchronous active-low reset.
- load_start, input, 1, one-cycle request to begin receiving a frame.
- rx_byte, input, BYTE_W, UART payload; stable while rx_complete_async is high and for 3 clk after it.
- rx_complete_async, input, 1, UART-domain completion strobe; asynchronous to clk.
- pix_addr, input, ADDR_W, engine read address.
- pix_data, output, PIX_W, registered pixel at pix_addr.
- nn_start, output, 1, one-cycle engine start pulse.
- nn_done, input, 1, engine completion pulse.
- nn_class, input, CLS_W, engine result; valid when nn_done=1.
- class_out, output, CLS_W, latched result.
- class_valid, output, 1, high from result latch until next load_start.
- frame_busy, output, 1, high in LOAD, READY and BUSY.
- overrun, output, 1, sticky flag for a byte dropped outside LOAD; cleared by load_start.

Behaviour:
- Reset values: all outputs 0, state IDLE, byte and pixel counters 0. Buffer contents are not reset.
- Strobe capture: rx_complete_async passes through a 2-flop synchronizer, then rising-edge detect, producing byte_stb (one clk). rx_byte is sampled on the byte_stb cycle. Latency is 3 clk from the async rising edge to capture.
- IDLE: on load_start go to LOAD. Clear counters, overrun and class_valid.
- LOAD, byte assembly:
  - Byte order is little-endian: first byte goes to the low half-register.
  - On the second byte, write {byte, low} to buf[pix_cnt] and increment pix_cnt.
  - When the pixel at index N_PIX-1 is written, go to READY on the next cycle. The byte phase returns to 0.
- load_start while in LOAD restarts: counters clear, and pixels already written are overwritten later.
- READY: assert nn_start for exactly one cycle, then go to BUSY.
- BUSY:
  - On nn_done, set class_out = nn_class and class_valid = 1, then go to IDLE.
  - load_start in BUSY or READY is ignored.
- Dropped bytes: byte_stb in IDLE, READY or BUSY drops the byte and sets overrun. If load_start and byte_stb fall in the same IDLE cycle, load_start wins and the byte is dropped, with overrun set after the clear.
- Read port:
  - pix_data = buf[pix_addr] registered, 1-cycle latency, valid in every state.
  - pix_addr >= N_PIX returns 0.
  - A write and a read of the same address in the same cycle returns the old data.
- nn_done outside BUSY is ignored.
- rst_n low mid-frame: immediate return to IDLE, partial frame discarded, nn_start low.

Decomposition:
- Shared package nn_io_pkg holds: N_PIX, PIX_W, BYTE_W, ADDR_W, CLS_W, and the state encoding IDLE=0, LOAD=1, READY=2, BUSY=3.
- One sub-module, rx_strobe_sync: 2-flop synchronizer plus rising-edge detector producing byte_stb.
- Buffer is an inferred single-write, single-read registered RAM inside the top of this block.

Test Plan:
- Reset then idle: rst_n low, then high → all outputs 0. A 5-cycle async strobe in IDLE → overrun=1, with no state change.
- Full frame: load_start, then 1568 bytes where pixel k = 16'h0100*k[7:0] + k[7:0] → nn_start pulses exactly once, 1 cycle after the last write. pix_addr=0x30F gives pix_data 16'h0F0F on the next cycle.
- Byte order: first two bytes 0x34 then 0x12 → buf[0] = 16'h1234, frame_busy=1, pix_cnt=1.
- Completion: in BUSY, nn_done with nn_class=4'd7 → class_out=7, class_valid=1, state IDLE. A next load_start → class_valid=0.
- Restart mid-load: 300 bytes, then load_start, then 1568 bytes → exactly one nn_start, and buf[0] holds the post-restart value.
- Async reset mid-BUSY: rst_n low for 2 cycles → frame_busy=0. A later nn_done does not set class_valid.
